// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES constant tables, state encoding and permutation helpers
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        FINAL = 2'd3
    } state_t;

    localparam int SHIFT_ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SHIFT_DEC [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Table entries are 1-based DES bit numbers; DES bit 1 is the vector MSB.
    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TAB[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TAB[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_TAB[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_TAB[i]];
        return y;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        case (n)
            1:       return {x[26:0], x[27]};
            2:       return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
        case (n)
            1:       return {x[0], x[27:1]};
            2:       return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_round_ctrl_if.sv
// rtl/des_round_ctrl_if.sv - request/result and des_f signals of the DES round controller
interface des_round_ctrl_if;
    logic        start;
    logic        decrypt;
    logic [63:0] data_in;
    logic [63:0] key_in;
    logic [31:0] f_out;
    logic [31:0] f_r;
    logic [47:0] f_subkey;
    logic        busy;
    logic        done;
    logic [3:0]  round;
    logic [63:0] data_out;

    modport master (
        output start, decrypt, data_in, key_in, f_out,
        input  f_r, f_subkey, busy, done, round, data_out
    );

    modport slave (
        input  start, decrypt, data_in, key_in, f_out,
        output f_r, f_subkey, busy, done, round, data_out
    );
endinterface

// File: rtl/des_keysched.sv
// rtl/des_keysched.sv - on-the-fly DES subkey generator (C/D registers, rotation, PC-2)
module des_keysched
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load,
    input  logic        advance,
    input  logic        decrypt,
    input  logic [63:0] key,
    input  logic [3:0]  round,
    output logic [47:0] subkey
);
    logic [27:0] c, d;
    logic [27:0] c_next, d_next;
    logic [55:0] cd_init;

    assign cd_init = pc1_f(key);

    // Decrypt walks the schedule backwards: round 0 uses C0/D0 unrotated, giving K16.
    always_comb begin
        c_next = c;
        d_next = d;
        if (decrypt) begin
            c_next = rotr28(c, SHIFT_DEC[round]);
            d_next = rotr28(d, SHIFT_DEC[round]);
        end else begin
            c_next = rotl28(c, SHIFT_ENC[round]);
            d_next = rotl28(d, SHIFT_ENC[round]);
        end
    end

    assign subkey = advance ? pc2_f({c_next, d_next}) : 48'd0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            c <= 28'd0;
            d <= 28'd0;
        end else if (load) begin
            c <= cd_init[55:28];
            d <= cd_init[27:0];
        end else if (advance) begin
            c <= c_next;
            d <= d_next;
        end
    end
endmodule

// File: rtl/des_round_ctrl.sv
// rtl/des_round_ctrl.sv - iterative 16-round DES controller driving an external des_f
module des_round_ctrl
    import des_pkg::*;
(
    input  logic            clk,
    input  logic            n_rst,
    des_round_ctrl_if.slave bus
);
    state_t      state;
    logic [63:0] data_cap;
    logic [63:0] key_cap;
    logic        dec_cap;
    logic [31:0] l, r;
    logic [3:0]  round_q;
    logic        busy_q;
    logic        done_q;
    logic [63:0] data_out_q;

    des_keysched u_keysched (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (state == LOAD),
        .advance (state == ROUND),
        .decrypt (dec_cap),
        .key     (key_cap),
        .round   (round_q),
        .subkey  (bus.f_subkey)
    );

    assign bus.f_r      = r;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.round    = round_q;
    assign bus.data_out = data_out_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            data_cap   <= 64'd0;
            key_cap    <= 64'd0;
            dec_cap    <= 1'b0;
            l          <= 32'd0;
            r          <= 32'd0;
            round_q    <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= 64'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        data_cap <= bus.data_in;
                        key_cap  <= bus.key_in;
                        dec_cap  <= bus.decrypt;
                        busy_q   <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    {l, r}  <= ip_f(data_cap);
                    round_q <= 4'd0;
                    state   <= ROUND;
                end
                ROUND: begin
                    l <= r;
                    r <= l ^ bus.f_out;
                    if (round_q == 4'd15) begin
                        round_q <= 4'd0;
                        state   <= FINAL;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                FINAL: begin
                    // Swapping to {R,L} undoes the last round's half exchange.
                    data_out_q <= fp_f({r, l});
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_round_ctrl.sv
// tb/tb_des_round_ctrl.sv - bench for des_round_ctrl with a behavioural des_f and DES reference
module tb_des_round_ctrl;
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    des_round_ctrl_if bus();

    des_round_ctrl dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [31:0] f_fn(input logic [31:0] rr, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        int          row, col;
        for (int i = 0; i < 48; i++) e[47-i] = rr[32-E_T[i]];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            b   = e[47-6*j -: 6];
            row = int'({b[5], b[0]});
            col = int'(b[4:1]);
            s[31-4*j -: 4] = 4'(SBOX[j][row*16+col]);
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] data, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] p, q, y;
        logic [31:0] l, r, t;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < SHIFTS[n]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) p[63-i] = data[64-IP_T[i]];
        l = p[63:32];
        r = p[31:0];
        for (int n = 0; n < 16; n++) begin
            t = r;
            r = l ^ f_fn(r, ks[dec ? 15 - n : n]);
            l = t;
        end
        q = {r, l};
        for (int i = 0; i < 64; i++) y[64-IP_T[i]] = q[63-i];
        return y;
    endfunction

    assign bus.f_out = f_fn(bus.f_r, bus.f_subkey);

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic [63:0] res;
    int          lat;
    logic [47:0] k0;
    int          bcnt;

    task automatic run_op(input logic [63:0] k, input logic [63:0] dat, input logic dec);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.key_in  = k;
        bus.data_in = dat;
        bus.decrypt = dec;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.key_in  = {$urandom, $urandom};
        bus.data_in = {$urandom, $urandom};
        bus.decrypt = ~dec;
        lat  = 0;
        bcnt = 0;
        k0   = 48'd0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) bcnt++;
            if (lat == 1) k0 = bus.f_subkey;
            @(negedge clk);
            lat++;
        end
        res = bus.data_out;
    endtask

    typedef struct packed {
        logic [63:0] key;
        logic [63:0] data;
        logic        dec;
        logic [63:0] exp_out;
        logic [47:0] exp_k0;
    } vec_t;

    vec_t        vecs [3];
    logic [63:0] k, x, y, w;
    int          cyc, gap;
    logic        seen_done, seen_busy, seen_nz;

    initial begin
        vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 48'h1B02EFFC7072};
        vecs[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF, 48'hCB3D8B0E17F5};
        vecs[2] = '{64'h0, 64'h0, 1'b0, 64'h8CA64DE9C1B123A7, 48'h0};

        bus.start = 1'b0; bus.decrypt = 1'b0; bus.data_in = 64'd0; bus.key_in = 64'd0;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #2;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_round", 64'(bus.round), 64'd0);
        chk("rst_data_out", bus.data_out, 64'd0);
        chk("rst_f_r", 64'(bus.f_r), 64'd0);
        chk("rst_f_subkey", 64'(bus.f_subkey), 64'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        for (int v = 0; v < 3; v++) begin
            run_op(vecs[v].key, vecs[v].data, vecs[v].dec);
            chk($sformatf("vec%0d_latency", v), 64'(lat), 64'd18);
            chk($sformatf("vec%0d_data_out", v), res, vecs[v].exp_out);
            chk($sformatf("vec%0d_round0_subkey", v), 64'(k0), 64'(vecs[v].exp_k0));
            chk($sformatf("vec%0d_busy_cycles", v), 64'(bcnt), 64'd18);
            chk($sformatf("vec%0d_busy_low_at_done", v), 64'(bus.busy), 64'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_one_cycle", v), 64'(bus.done), 64'd0);
        end

        // Starts while busy must be ignored; start held in the done cycle is accepted.
        @(negedge clk);
        bus.start = 1'b1; bus.key_in = vecs[0].key; bus.data_in = vecs[0].data; bus.decrypt = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (cyc == 5 || cyc == 10) begin
                bus.start = 1'b1; bus.key_in = {$urandom, $urandom};
                bus.data_in = {$urandom, $urandom}; bus.decrypt = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("ignored_start_latency", 64'(cyc), 64'd18);
        chk("ignored_start_data_out", bus.data_out, 64'h85E813540F0AB405);
        bus.start = 1'b1; bus.key_in = vecs[0].key; bus.data_in = 64'hFEDCBA9876543210; bus.decrypt = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        gap = 1;
        while (bus.done !== 1'b1 && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        chk("back_to_back_gap", 64'(gap), 64'd19);
        chk("back_to_back_data_out", bus.data_out, des_ref(vecs[0].key, 64'hFEDCBA9876543210, 1'b0));

        // Abort in the middle of round 7.
        @(negedge clk);
        bus.start = 1'b1; bus.key_in = 64'h0E329232EA6D0D73; bus.data_in = 64'h8787878787878787; bus.decrypt = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.round !== 4'd7 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_round7", 64'(bus.round), 64'd7);
        #2 n_rst = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_round", 64'(bus.round), 64'd0);
        chk("abort_data_out", bus.data_out, 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_f_subkey", 64'(bus.f_subkey), 64'd0);
        chk("abort_f_r", 64'(bus.f_r), 64'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        seen_done = 1'b0; seen_busy = 1'b0; seen_nz = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done = 1'b1;
            if (bus.busy !== 1'b0) seen_busy = 1'b1;
            if (bus.data_out !== 64'd0 || bus.round !== 4'd0) seen_nz = 1'b1;
        end
        chk("post_abort_no_done", 64'(seen_done), 64'd0);
        chk("post_abort_idle", 64'(seen_busy), 64'd0);
        chk("post_abort_outputs_zero", 64'(seen_nz), 64'd0);

        for (int i = 0; i < 100; i++) begin
            k = {$urandom, $urandom};
            x = {$urandom, $urandom};
            w = {$urandom, $urandom};
            run_op(k, x, 1'b0);
            y = res;
            chk($sformatf("rand%0d_encrypt", i), y, des_ref(k, x, 1'b0));
            run_op(k, y, 1'b1);
            chk($sformatf("rand%0d_roundtrip", i), res, x);
            run_op(k, w, 1'b1);
            chk($sformatf("rand%0d_decrypt", i), res, des_ref(k, w, 1'b1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Iterative DES round controller for the USB encryptor datapath. It accepts a 64-bit block and a 64-bit key, applies the initial permutation and PC-1, then sequences 16 rounds through one shared f-function (expansion, key XOR, S-boxes sb1–sb8, P). It generates each round subkey on the fly for both encrypt and decrypt, applies the final permutation, and returns the result with a done pulse. It sits between the packet buffer and the des_f datapath instance; des_f stays combinational and external.

## Interface
- No parameters. Round count (16) and all permutation tables are fixed constants in the package.
- clk  in  1  system clock, rising-edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled with start.
- data_in  in  64  input block; bit 63 = DES bit 1; sampled with start.
- key_in  in  64  key including parity bits; bit 63 = DES bit 1; sampled with start.
- f_out  in  32  result of des_f for the current (f_r, f_subkey).
- f_r  out  32  current R half, driven to des_f.
- f_subkey  out  48  current round subkey, driven to des_f.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when data_out updates.
- round  out  4  current round index 0–15; 0 outside ROUND.
- data_out  out  64  last result; holds until the next completion.

## Operation
- States:
  - IDLE: waits for start. On start=1, captures data_in, key_in and decrypt, then goes to LOAD.
  - LOAD: L,R <= IP(data_in); C,D <= PC1(key_in) (28 bits each); round <= 0; goes to ROUND.
  - ROUND: on each edge, L <= R; R <= L ^ f_out; C,D <= cd_next; round += 1. The edge with round=15 goes to FINAL and round returns to 0.
  - FINAL: data_out <= FP({R,L}), which includes the final swap; done <= 1; goes to IDLE.
- Key schedule (combinational from the C,D registers and round):
  - Encrypt: cd_next = rotl(C,shift_enc[round]) and rotl(D,shift_enc[round]), with shift_enc = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt: rotr by shift_dec = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - f_subkey = PC2({cd_next}) in ROUND and 0 otherwise.
- f_r = R in every state.
- Rotations are within each 28-bit half. Parity bits are discarded by PC-1 and never checked.
- start while busy is ignored; no queueing. decrypt, data_in and key_in may change freely after capture.
- Back-to-back operation: start may be high in the cycle done is high, since the state is then IDLE. It is accepted and begins LOAD.
- Reset values: busy=0, done=0, round=0, data_out=0, f_r=0, f_subkey=0; internal L,R,C,D=0; state=IDLE.
- Reset mid-operation aborts immediately: outputs go to reset values, no done is produced, and data_out is cleared.

## Timing
- Let edge 0 be the edge that samples start=1 in IDLE. LOAD completes at edge 1 and rounds complete at edges 2–17.
- FINAL registers data_out and done at edge 18. done is high for exactly the cycle after edge 18.
- Latency is therefore 18 cycles from start sample to done; throughput is one block per 19 cycles (the IDLE cycle plus 18).
- busy rises after edge 0 and falls after edge 18, in the same cycle done rises.
- f_out must settle within one cycle of f_r/f_subkey (single-cycle combinational path through des_f); no multicycle paths.
- All outputs are registered, except f_subkey, which is combinational from registered state.

## Structure
- Package des_pkg holds:
  - state enum (IDLE, LOAD, ROUND, FINAL);
  - shift_enc and shift_dec constant arrays;
  - IP, FP, PC1 and PC2 as constant index arrays plus permute functions (ip_f, fp_f, pc1_f, pc2_f).
- One sub-module is natural: des_keysched (C,D registers, rotate logic, PC-2), instantiated once inside des_round_ctrl.
- des_f (with sb1–sb8) is instantiated alongside des_round_ctrl by the parent, not inside it.

## Test plan
- Encrypt, key 133457799BBCDFF1, data 0123456789ABCDEF, real des_f attached -> done 18 cycles after start; data_out = 85E813540F0AB405. In ROUND with round=0, f_subkey = 1B02EFFC7072.
- Decrypt, same key, data 85E813540F0AB405 -> data_out = 0123456789ABCDEF. In ROUND with round=0, f_subkey = CB3D8B0E17F5 (K16).
- All-zero key and data, encrypt -> data_out = 8CA64DE9C1B123A7; busy high for exactly 18 cycles.
- start pulsed at cycles 5 and 10 after an accepted start -> both ignored. Then start held high in the done cycle -> second operation accepted; two done pulses 19 cycles apart.
- n_rst asserted at round=7 -> asynchronously busy=0, round=0, data_out=0, no done. After release with no start, outputs stay at reset values.
- Sweep 100 random key/data pairs against a reference DES model, in both directions -> exact match. Also check decrypt(encrypt(x)) = x.
